// File: rtl/mux2_arbiter.sv
// Two-requester round-robin arbiter feeding a one-word registered output slot.
// Optional MUX2_ARBITER_LOCK_EN adds i_lock_a/i_lock_b to pin the grant to one side.
module mux2_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_a_data,
  input  logic             i_a_valid,
  output logic             o_a_ready,
  input  logic [WIDTH-1:0] i_b_data,
  input  logic             i_b_valid,
  output logic             o_b_ready,
`ifdef MUX2_ARBITER_LOCK_EN
  input  logic             i_lock_a,
  input  logic             i_lock_b,
`endif
  output logic [WIDTH-1:0] o_y_data,
  output logic             o_y_valid,
  input  logic             i_y_ready,
  output logic             o_sel
);

  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_y_data;
  logic             r_sel;
  logic             r_last;
  logic             w_slot_free;
  logic             w_a_req;
  logic             w_b_req;
  logic             w_gnt_vld;
  logic             w_gnt_side;

`ifdef MUX2_ARBITER_LOCK_EN
  logic r_locked;
  logic r_lock_side;
`endif

  always_comb begin
    w_a_req = i_a_valid;
    w_b_req = i_b_valid;
`ifdef MUX2_ARBITER_LOCK_EN
    // A lock masks the other side even while the owner is idle.
    if (r_locked) begin
      if (r_lock_side) w_a_req = 1'b0;
      else             w_b_req = 1'b0;
    end
`endif
    w_slot_free = (r_state == S_EMPTY) || i_y_ready;
    w_gnt_vld   = 1'b0;
    w_gnt_side  = 1'b0;
    if (i_rst_n && w_slot_free) begin
      if (w_a_req && w_b_req) begin
        w_gnt_vld  = 1'b1;
        w_gnt_side = ~r_last;
      end else if (w_a_req) begin
        w_gnt_vld  = 1'b1;
        w_gnt_side = 1'b0;
      end else if (w_b_req) begin
        w_gnt_vld  = 1'b1;
        w_gnt_side = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_gnt_vld) w_state_nxt = S_FULL;
    else if (r_state == S_FULL && i_y_ready) w_state_nxt = S_EMPTY;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_EMPTY;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_y_data <= '0;
      r_sel    <= 1'b0;
      r_last   <= 1'b1;
    end else if (w_gnt_vld) begin
      r_y_data <= w_gnt_side ? i_b_data : i_a_data;
      r_sel    <= w_gnt_side;
      r_last   <= w_gnt_side;
    end
  end

`ifdef MUX2_ARBITER_LOCK_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_locked    <= 1'b0;
      r_lock_side <= 1'b0;
    end else if (w_gnt_vld) begin
      r_locked    <= w_gnt_side ? i_lock_b : i_lock_a;
      r_lock_side <= w_gnt_side;
    end
  end
`endif

  assign o_a_ready = w_gnt_vld & ~w_gnt_side;
  assign o_b_ready = w_gnt_vld &  w_gnt_side;
  assign o_sel     = w_gnt_vld ? w_gnt_side : r_sel;
  assign o_y_valid = (r_state == S_FULL);
  assign o_y_data  = r_y_data;

endmodule
